univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, a WIDTH-bit value loaded into the register by reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; port names are clk and reset.
REQ-004 Port clk SHALL be input, 1 bit, the rising-edge clock for all state.
REQ-005 Port reset SHALL be input, 1 bit, the synchronous active-high reset.
REQ-006 Port en SHALL be input, 1 bit, the operation enable.
REQ-007 Port mode SHALL be input, 3 bits, the operation select.
REQ-008 Port d SHALL be input, WIDTH bits, the parallel load data.
REQ-009 Port sin_l SHALL be input, 1 bit, the serial data entering at the LSB on shift-left.
REQ-010 Port sin_r SHALL be input, 1 bit, the serial data entering at the MSB on shift-right.
REQ-011 Port q SHALL be output, WIDTH bits, the register contents.
REQ-012 Port q_n SHALL be output, WIDTH bits, the bitwise complement of q.
REQ-013 Port sout_l SHALL be output, 1 bit, equal to q[WIDTH-1], the cascade output for shift-left.
REQ-014 Port sout_r SHALL be output, 1 bit, equal to q[0], the cascade output for shift-right.
REQ-015 Port busy_edge SHALL be output, 1 bit, a registered flag that is high for one cycle after any clock edge on which q changed value.

Function
REQ-016 All state SHALL update only on the rising edge of clk; q, busy_edge are registers, and q_n, sout_l, sout_r are combinational from q.
REQ-017 With en=0 and reset=0, q SHALL hold regardless of mode, d, sin_l and sin_r.
REQ-018 With en=1, mode SHALL select the next q: 000 hold; 001 load (q<=d); 010 shl (q<={q[W-2:0],sin_l}); 011 shr (q<={sin_r,q[W-1:1]}).
REQ-019 With en=1, mode SHALL further select: 100 rotl (q<={q[W-2:0],q[W-1]}); 101 rotr (q<={q[0],q[W-1:1]}); 110 invert (q<=~q); 111 clear (q<=0, not RESET_VALUE).
REQ-020 Every operation SHALL take effect in exactly one clock cycle, with q valid immediately after the edge.
REQ-021 The bit shifted out by shl/shr SHALL be the pre-edge sout_l/sout_r, so that two instances chained sout_l->sin_l act as one 2*WIDTH register.
REQ-022 busy_edge SHALL be 1 on the cycle after an edge where the new q differs from the old q, and 0 otherwise, including hold, load of the same value, and rotate of all-equal bits.
REQ-023 q_n SHALL equal ~q at all times, including during and directly after reset.

Reset
REQ-024 When reset=1 at a rising edge, q SHALL be set to RESET_VALUE and busy_edge to 0, overriding en and every mode.
REQ-025 A reset asserted in the middle of a multi-cycle shift sequence SHALL abort it; after reset deasserts, the first enabled operation SHALL act on RESET_VALUE.
REQ-026 The block SHALL have no asynchronous behaviour; reset pulses that do not span a rising edge SHALL have no effect.

Verification
REQ-027 WIDTH=8, RESET_VALUE=8'hA5, reset one cycle -> q=A5, q_n=5A, sout_l=1, sout_r=1, busy_edge=0.
REQ-028 Load 8'h81, then four cycles of shl with sin_l=0 -> q=02, 04, 08, 10, with sout_l before each edge equal to 1, 0, 0, 0.
REQ-029 Load 8'h01, rotr one cycle -> q=80; then rotl one cycle -> q=01; busy_edge=1 after each edge.
REQ-030 q=3C with en=0 and mode toggling through all 8 codes for 8 cycles -> q stays 3C and busy_edge stays 0.
REQ-031 Two instances chained (sout_l->sin_l), loaded 8'h80 and 8'h00, shl for one cycle -> upper=01, lower=00; invert, then clear -> FE/FF, then 00/00.
REQ-032 Shr in progress (load F0, shr twice) with reset asserted on the third edge alongside en=1, mode=001 -> q=RESET_VALUE; the next shr with sin_r=1 -> q={1,RESET_VALUE[7:1]}.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, shift, rotate, invert and clear,
// with cascade outputs and a one-cycle flag marking edges where the contents changed.
module univ_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy_edge
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHL    = 3'b010,
    MODE_SHR    = 3'b011,
    MODE_ROTL   = 3'b100,
    MODE_ROTR   = 3'b101,
    MODE_INVERT = 3'b110,
    MODE_CLEAR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic [WIDTH-1:0] w_next;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  always_comb begin
    w_next = r_q;
    if (en) begin
      case (w_mode)
        MODE_HOLD:   w_next = r_q;
        MODE_LOAD:   w_next = d;
        MODE_SHL:    w_next = {r_q[WIDTH-2:0], sin_l};
        MODE_SHR:    w_next = {sin_r, r_q[WIDTH-1:1]};
        MODE_ROTL:   w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROTR:   w_next = {r_q[0], r_q[WIDTH-1:1]};
        MODE_INVERT: w_next = ~r_q;
        MODE_CLEAR:  w_next = '0;
        default:     w_next = r_q;
      endcase
    end
  end

  // Busy compares against the pre-edge contents, so no-op operations never flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= RESET_VALUE;
      r_busy <= 1'b0;
    end else begin
      r_q    <= w_next;
      r_busy <= (w_next != r_q);
    end
  end

  assign q         = r_q;
  assign q_n       = ~r_q;
  assign sout_l    = r_q[WIDTH-1];
  assign sout_r    = r_q[0];
  assign busy_edge = r_busy;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg: a standalone instance with a
// non-zero reset value and a two-instance chain acting as one 16-bit register.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic [7:0] q, q_n;
  logic       sout_l, sout_r, busy_edge;

  logic [7:0] dLo = 8'h00, dUp = 8'h00;
  logic [7:0] qLo, qnLo, qUp, qnUp;
  logic       soutlLo, soutrLo, busyLo;
  logic       soutlUp, soutrUp, busyUp;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011,
                         M_ROTL = 3'b100, M_ROTR = 3'b101, M_INV = 3'b110, M_CLR = 3'b111;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .q(q), .q_n(q_n), .sout_l(sout_l), .sout_r(sout_r), .busy_edge(busy_edge)
  );

  // Lower instance feeds its MSB into the upper instance's LSB.
  univ_shift_reg #(.WIDTH(8)) chainLo (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(dLo), .sin_l(1'b0), .sin_r(1'b0),
    .q(qLo), .q_n(qnLo), .sout_l(soutlLo), .sout_r(soutrLo), .busy_edge(busyLo)
  );

  univ_shift_reg #(.WIDTH(8)) chainUp (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(dUp), .sin_l(soutlLo), .sin_r(1'b0),
    .q(qUp), .q_n(qnUp), .sout_l(soutlUp), .sout_r(soutrUp), .busy_edge(busyUp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doOp(input logic [2:0] m, input logic [7:0] dv);
    en = 1'b1; mode = m; d = dv;
    step();
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = M_LOAD; d = 8'h00;
    step();
    reset = 1'b0; en = 1'b0;
    total++; if (q !== 8'hA5) begin bad++; $display("[TB] FAIL reset_q actual=%h required=a5", q); end
    total++; if (q_n !== 8'h5A) begin bad++; $display("[TB] FAIL reset_qn actual=%h required=5a", q_n); end
    total++; if (sout_l !== 1'b1 || sout_r !== 1'b1) begin bad++; $display("[TB] FAIL reset_sout actual=%b%b required=11", sout_l, sout_r); end
    total++; if (busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy actual=%b required=0", busy_edge); end
    // Reset pulse that falls between edges must not affect state.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step();
    total++; if (q !== 8'hA5) begin bad++; $display("[TB] FAIL reset_glitch actual=%h required=a5", q); end
  endtask

  task automatic test_shl();
    logic [7:0] expQ [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
    logic       expSo[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    doOp(M_LOAD, 8'h81);
    total++; if (q !== 8'h81) begin bad++; $display("[TB] FAIL shl_load actual=%h required=81", q); end
    sin_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (sout_l !== expSo[i]) begin bad++; $display("[TB] FAIL shl_sout%0d actual=%b required=%b", i, sout_l, expSo[i]); end
      doOp(M_SHL, 8'h00);
      total++; if (q !== expQ[i]) begin bad++; $display("[TB] FAIL shl_q%0d actual=%h required=%h", i, q, expQ[i]); end
    end
  endtask

  task automatic test_rotate();
    doOp(M_LOAD, 8'h01);
    doOp(M_ROTR, 8'h00);
    total++; if (q !== 8'h80) begin bad++; $display("[TB] FAIL rotr_q actual=%h required=80", q); end
    total++; if (busy_edge !== 1'b1) begin bad++; $display("[TB] FAIL rotr_busy actual=%b required=1", busy_edge); end
    doOp(M_ROTL, 8'h00);
    total++; if (q !== 8'h01) begin bad++; $display("[TB] FAIL rotl_q actual=%h required=01", q); end
    total++; if (busy_edge !== 1'b1) begin bad++; $display("[TB] FAIL rotl_busy actual=%b required=1", busy_edge); end
    doOp(M_LOAD, 8'hB4);
    doOp(M_ROTL, 8'h00);
    total++; if (q !== 8'h69) begin bad++; $display("[TB] FAIL rotl_b4 actual=%h required=69", q); end
    doOp(M_ROTR, 8'h00);
    doOp(M_ROTR, 8'h00);
    total++; if (q !== 8'h5A) begin bad++; $display("[TB] FAIL rotr_b4 actual=%h required=5a", q); end
  endtask

  task automatic test_shr();
    doOp(M_LOAD, 8'h96);
    sin_r = 1'b1;
    doOp(M_SHR, 8'h00);
    total++; if (q !== 8'hCB) begin bad++; $display("[TB] FAIL shr_in1 actual=%h required=cb", q); end
    sin_r = 1'b0;
    doOp(M_SHR, 8'h00);
    total++; if (q !== 8'h65) begin bad++; $display("[TB] FAIL shr_in0 actual=%h required=65", q); end
  endtask

  task automatic test_hold();
    doOp(M_LOAD, 8'h3C);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mode = 3'(i); d = 8'(8'hC3 ^ i); sin_l = i[0]; sin_r = ~i[0];
      step();
      total++; if (q !== 8'h3C) begin bad++; $display("[TB] FAIL hold_q%0d actual=%h required=3c", i, q); end
      total++; if (busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL hold_busy%0d actual=%b required=0", i, busy_edge); end
    end
    doOp(M_HOLD, 8'hFF);
    total++; if (q !== 8'h3C || busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL hold_en1 actual=%h/%b required=3c/0", q, busy_edge); end
  endtask

  task automatic test_busy_same();
    doOp(M_LOAD, 8'h3C);
    total++; if (busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL busy_sameload actual=%b required=0", busy_edge); end
    doOp(M_LOAD, 8'hFF);
    total++; if (busy_edge !== 1'b1) begin bad++; $display("[TB] FAIL busy_newload actual=%b required=1", busy_edge); end
    doOp(M_ROTL, 8'h00);
    total++; if (q !== 8'hFF || busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL busy_rotones actual=%h/%b required=ff/0", q, busy_edge); end
    doOp(M_INV, 8'h00);
    total++; if (q !== 8'h00 || q_n !== 8'hFF || busy_edge !== 1'b1) begin bad++; $display("[TB] FAIL invert actual=%h/%h/%b required=00/ff/1", q, q_n, busy_edge); end
    doOp(M_CLR, 8'h00);
    total++; if (q !== 8'h00 || busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL clear_zero actual=%h/%b required=00/0", q, busy_edge); end
    doOp(M_LOAD, 8'h5A);
    doOp(M_CLR, 8'h00);
    total++; if (q !== 8'h00 || busy_edge !== 1'b1) begin bad++; $display("[TB] FAIL clear_nz actual=%h/%b required=00/1", q, busy_edge); end
  endtask

  task automatic test_chain();
    dLo = 8'h80; dUp = 8'h00;
    doOp(M_LOAD, 8'h00);
    doOp(M_SHL, 8'h00);
    total++; if (qUp !== 8'h01 || qLo !== 8'h00) begin bad++; $display("[TB] FAIL chain_shl actual=%h/%h required=01/00", qUp, qLo); end
    doOp(M_INV, 8'h00);
    total++; if (qUp !== 8'hFE || qLo !== 8'hFF) begin bad++; $display("[TB] FAIL chain_inv actual=%h/%h required=fe/ff", qUp, qLo); end
    doOp(M_CLR, 8'h00);
    total++; if (qUp !== 8'h00 || qLo !== 8'h00) begin bad++; $display("[TB] FAIL chain_clr actual=%h/%h required=00/00", qUp, qLo); end
  endtask

  task automatic test_reset_abort();
    sin_r = 1'b0;
    doOp(M_LOAD, 8'hF0);
    doOp(M_SHR, 8'h00);
    doOp(M_SHR, 8'h00);
    total++; if (q !== 8'h3C) begin bad++; $display("[TB] FAIL abort_pre actual=%h required=3c", q); end
    reset = 1'b1;
    doOp(M_LOAD, 8'hFF);
    reset = 1'b0;
    total++; if (q !== 8'hA5 || q_n !== 8'h5A || busy_edge !== 1'b0) begin bad++; $display("[TB] FAIL abort_reset actual=%h/%h/%b required=a5/5a/0", q, q_n, busy_edge); end
    sin_r = 1'b1;
    doOp(M_SHR, 8'h00);
    total++; if (q !== 8'hD2 || busy_edge !== 1'b1) begin bad++; $display("[TB] FAIL abort_next actual=%h/%b required=d2/1", q, busy_edge); end
    sin_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shl();
    test_rotate();
    test_shr();
    test_hold();
    test_busy_same();
    test_chain();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
